// File: rtl/wb_stage.sv
// Write-back stage: W pipeline register, 15-entry register file,
// program status tracking, sticky halt and retired-instruction counter.
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  m_icode,
   input  logic [63:0] m_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  m_dstE,
   input  logic [3:0]  m_dstM,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   output logic [63:0] d_rvalA,
   output logic [63:0] d_rvalB,
   output logic [3:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  Stat,
   output logic        halted,
   output logic [31:0] retired
);

   localparam logic [3:0] STAT_AOK = 4'b0001;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] R_NONE   = 4'hF;

   logic [63:0] rf [0:14];
   logic [3:0]  stat_q;
   logic [31:0] cnt_q;
   logic        w_aok;
   logic        we_e;
   logic        we_m;
   logic        cnt_en;

   assign w_aok  = (W_stat == STAT_AOK);
   // valM wins a same-register conflict, so the E port steps aside
   assign we_e   = !halted && w_aok && (W_dstE != R_NONE)
                   && (W_dstE != W_dstM);
   assign we_m   = !halted && w_aok && (W_dstM != R_NONE);
   assign cnt_en = !halted && w_aok && (W_icode != I_NOP)
                   && !W_stall && (cnt_q != 32'hFFFF_FFFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         W_stat  <= STAT_AOK;
         W_icode <= I_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= R_NONE;
         W_dstM  <= R_NONE;
      end else if (!halted && !W_stall) begin
         if (W_bubble) begin
            W_stat  <= STAT_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= R_NONE;
            W_dstM  <= R_NONE;
         end else begin
            W_stat  <= m_stat;
            W_icode <= m_icode;
            W_valE  <= m_valE;
            W_valM  <= m_valM;
            W_dstE  <= m_dstE;
            W_dstM  <= m_dstM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) rf[i] <= '0;
      end else begin
         if (we_e) rf[W_dstE] <= W_valE;
         if (we_m) rf[W_dstM] <= W_valM;
      end
   end

   // Stat is latched at the halting edge because W still captures there
   always_ff @(posedge clk) begin
      if (rst) begin
         halted <= 1'b0;
         stat_q <= STAT_AOK;
         cnt_q  <= '0;
      end else if (!halted) begin
         if (!w_aok) begin
            halted <= 1'b1;
            stat_q <= W_stat;
         end
         if (cnt_en) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign d_rvalA = (d_srcA == R_NONE) ? 64'h0 : rf[d_srcA];
   assign d_rvalB = (d_srcB == R_NONE) ? 64'h0 : rf[d_srcB];
   assign Stat    = halted ? stat_q : W_stat;
   assign retired = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios plus random traffic
// checked against an instruction-level model of write-back.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        W_stall = 1'b0;
   logic        W_bubble = 1'b0;
   logic [3:0]  m_stat = 4'b0001;
   logic [3:0]  m_icode = 4'h1;
   logic [63:0] m_valE = '0;
   logic [63:0] m_valM = '0;
   logic [3:0]  m_dstE = 4'hF;
   logic [3:0]  m_dstM = 4'hF;
   logic [3:0]  d_srcA = 4'hF;
   logic [3:0]  d_srcB = 4'hF;
   logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM;
   logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
   logic        halted;
   logic [31:0] retired;

   wb_stage dut (
      .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE),
      .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA),
      .d_rvalB(d_rvalB), .W_stat(W_stat), .W_icode(W_icode),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE),
      .W_valM(W_valM), .Stat(Stat), .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  stat, icode, dstE, dstM;
      logic [63:0] valE, valM;
   } ins_t;

   typedef struct {
      logic        rst, stall, bub;
      ins_t        m;
      logic [3:0]  srcA, srcB;
   } in_t;

   typedef struct {
      ins_t        w;
      logic [3:0]  stat_o;
      logic        halted;
      logic [31:0] ret;
      logic [63:0] ra, rb;
   } exp_t;

   localparam ins_t NOP = '{4'b0001, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0};

   exp_t        sb[$];
   ins_t        mw;
   logic [63:0] mregs [16];
   logic        mhalt;
   logic [3:0]  mfrz;
   logic [31:0] mret;
   logic        pend_force = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // One clock of stimulus; the model retires the instruction held in W
   task automatic drive(input in_t s);
      exp_t e;
      @(negedge clk);
      if (pend_force) begin
         force dut.cnt_q = 32'hFFFF_FFFE;
         #1;
         release dut.cnt_q;
         mret = 32'hFFFF_FFFE;
         pend_force = 1'b0;
      end
      rst = s.rst; W_stall = s.stall; W_bubble = s.bub;
      m_stat = s.m.stat; m_icode = s.m.icode;
      m_valE = s.m.valE; m_valM = s.m.valM;
      m_dstE = s.m.dstE; m_dstM = s.m.dstM;
      d_srcA = s.srcA; d_srcB = s.srcB;
      if (s.rst) begin
         mw = NOP;
         foreach (mregs[i]) mregs[i] = '0;
         mhalt = 1'b0;
         mfrz = 4'b0001;
         mret = '0;
      end else if (!mhalt) begin
         if (mw.stat == 4'b0001) begin
            if (mw.dstE != 4'hF) mregs[mw.dstE] = mw.valE;
            if (mw.dstM != 4'hF) mregs[mw.dstM] = mw.valM;
            if (mw.icode != 4'h1 && !s.stall && mret != 32'hFFFF_FFFF)
               mret = mret + 1;
         end else begin
            mhalt = 1'b1;
            mfrz = mw.stat;
         end
         if (!s.stall) mw = s.bub ? NOP : s.m;
      end
      mregs[15] = '0;
      e.w = mw;
      e.stat_o = mhalt ? mfrz : mw.stat;
      e.halted = mhalt;
      e.ret = mret;
      e.ra = mregs[s.srcA];
      e.rb = mregs[s.srcB];
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("W_stat", W_stat, e.w.stat);
            chk("W_icode", W_icode, e.w.icode);
            chk("W_dstE", W_dstE, e.w.dstE);
            chk("W_dstM", W_dstM, e.w.dstM);
            chk("W_valE", W_valE, e.w.valE);
            chk("W_valM", W_valM, e.w.valM);
            chk("Stat", Stat, e.stat_o);
            chk("halted", halted, e.halted);
            chk("retired", retired, e.ret);
            chk("d_rvalA", d_rvalA, e.ra);
            chk("d_rvalB", d_rvalB, e.rb);
         end
      end
   end

   function automatic in_t mk(input logic [3:0] st, input logic [3:0] ic,
                              input logic [63:0] ve, input logic [63:0] vm,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic [3:0] sa, input logic [3:0] sb_);
      in_t s;
      s.rst = 1'b0; s.stall = 1'b0; s.bub = 1'b0;
      s.m = '{st, ic, de, dm, ve, vm};
      s.srcA = sa; s.srcB = sb_;
      return s;
   endfunction

   function automatic in_t rnd();
      in_t s;
      int  p;
      p = $urandom_range(0, 99);
      s = mk(4'b0001, 4'($urandom_range(0, 11)),
             {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (p < 2) s.m.stat = 4'b0010;
      else if (p < 3) s.m.stat = 4'b0100;
      else if (p < 4) s.m.stat = 4'b1000;
      if ($urandom_range(0, 3) == 0) s.m.dstE = 4'hF;
      if ($urandom_range(0, 2) == 0) s.m.dstM = 4'hF;
      s.stall = ($urandom_range(0, 6) == 0);
      s.bub = ($urandom_range(0, 6) == 0);
      s.rst = ($urandom_range(0, 39) == 0);
      return s;
   endfunction

   initial begin : stim
      in_t s;
      mw = NOP; mhalt = 1'b0; mfrz = 4'b0001; mret = '0;
      foreach (mregs[i]) mregs[i] = '0;
      s = mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      s.rst = 1'b1;
      drive(s);
      drive(s);
      // basic write, then read back
      drive(mk(4'b0001, 4'h3, 64'h2A, 0, 4'h2, 4'hF, 4'h2, 4'hF));
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h2, 4'h0));
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h2, 4'hF));
      // dual-port conflict: valM wins
      drive(mk(4'b0001, 4'hB, 64'h100, 64'h55, 4'h4, 4'h4, 4'h4, 4'h2));
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h4, 4'h2));
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h4, 4'hF));
      // stall has priority over bubble, then bubble alone
      drive(mk(4'b0001, 4'h3, 64'h77, 0, 4'h5, 4'hF, 4'h5, 4'h4));
      for (int i = 0; i < 3; i++) begin
         s = mk(4'b0001, 4'h6, 64'hDEAD, 64'hBEEF, 4'h6, 4'h7,
                4'h5, 4'h6);
         s.stall = 1'b1; s.bub = 1'b1;
         drive(s);
      end
      s = mk(4'b0001, 4'h6, 64'hDEAD, 64'hBEEF, 4'h6, 4'h7, 4'h5, 4'h6);
      s.bub = 1'b1;
      drive(s);
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h5, 4'h6));
      // ADR fault halts and freezes everything
      drive(mk(4'b1000, 4'h5, 64'h999, 64'h888, 4'h3, 4'hF, 4'h3, 4'hF));
      for (int i = 0; i < 4; i++)
         drive(mk(4'b0001, 4'h3, 64'h1234, 0, 4'h3, 4'h8, 4'h3, 4'h8));
      // reset recovery
      s = mk(4'b0001, 4'h3, 64'h1234, 0, 4'h3, 4'h8, 4'h3, 4'h2);
      s.rst = 1'b1;
      drive(s);
      drive(mk(4'b0001, 4'h3, 64'hABC, 0, 4'h3, 4'hF, 4'h3, 4'h2));
      drive(mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'h3, 4'h2));
      // counter saturation
      pend_force = 1'b1;
      for (int i = 0; i < 3; i++)
         drive(mk(4'b0001, 4'h3, 64'(i), 0, 4'h9, 4'hF, 4'h9, 4'hF));
      for (int i = 0; i < 3; i++)
         drive(mk(4'b0001, 4'h2, 64'h5, 0, 4'hA, 4'hF, 4'hA, 4'h9));
      // random traffic, with occasional faults and resets
      s = mk(4'b0001, 4'h1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      s.rst = 1'b1;
      drive(s);
      for (int i = 0; i < 400; i++) drive(rnd());
      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
